// File: rtl/ddc_config_sequencer.sv
// Atomic reconfiguration sequencer for the DDC datapath: stage, mute, flush, settle.
// Optional SETTLE watchdog enabled by defining DDC_SEQ_TIMEOUT_EN.
module ddc_config_sequencer #(
  parameter int unsigned FLUSH_CYCLES   = 16,
  parameter int unsigned SETTLE_SAMPLES = 64,
  parameter int unsigned SETTLE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        cfgReq,
  input  logic        cfgBypassCic,
  input  logic        cfgBypassHb,
  input  logic        cfgBypassFir,
  input  logic        cfgEnableBb,
  input  logic [7:0]  cfgDecimation,
  input  logic [31:0] cfgCenterFreq,
  input  logic        syncIn,
  output logic        bypassCic,
  output logic        bypassHb,
  output logic        bypassFir,
  output logic        enableBasebandInputs,
  output logic [7:0]  adcDecimation,
  output logic [31:0] ddcCenterFreq,
  output logic        filterReset,
  output logic        outputValid,
  output logic        syncGate,
  output logic        cfgBusy,
  output logic        cfgDone,
  output logic        cfgTimeout
);

  if (FLUSH_CYCLES == 0 || SETTLE_SAMPLES == 0 || SETTLE_TIMEOUT == 0) begin : gBadParams
    $error("ddc_config_sequencer: FLUSH_CYCLES, SETTLE_SAMPLES and SETTLE_TIMEOUT must be > 0");
  end

  localparam int unsigned FlushW  = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [FlushW-1:0]  FlushLast  = FlushW'(FLUSH_CYCLES - 1);
  localparam logic [FlushW-1:0]  FlushMax   = FlushW'(FLUSH_CYCLES);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_SAMPLES - 1);
  localparam logic [SettleW-1:0] SettleMax  = SettleW'(SETTLE_SAMPLES);

  typedef enum logic [1:0] {StIdle, StMute, StFlush, StSettle} stateT;

  typedef struct packed {
    logic        bypassCic;
    logic        bypassHb;
    logic        bypassFir;
    logic        enableBb;
    logic [7:0]  decimation;
    logic [31:0] centerFreq;
  } cfgT;

  stateT              stateQ, stateD;
  logic [FlushW-1:0]  flushCntQ, flushCntD;
  logic [SettleW-1:0] settleCntQ, settleCntD;
  cfgT                shadowQ, shadowD;
  cfgT                appliedQ, appliedD;
  cfgT                reqCfg;
  logic               pendingQ, pendingD;
  logic               validQ, validD;
  logic               doneQ, doneD;
  logic               samplesDone;
  logic               timedOut;

`ifdef DDC_SEQ_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(SETTLE_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(SETTLE_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(SETTLE_TIMEOUT);

  logic [TimerW-1:0] timerQ, timerD;
  logic              timeoutQ, timeoutD;
`endif

  assign reqCfg = '{
    bypassCic:  cfgBypassCic,
    bypassHb:   cfgBypassHb,
    bypassFir:  cfgBypassFir,
    enableBb:   cfgEnableBb,
    decimation: cfgDecimation,
    centerFreq: cfgCenterFreq
  };

  always_comb begin
    stateD      = stateQ;
    flushCntD   = flushCntQ;
    settleCntD  = settleCntQ;
    shadowD     = shadowQ;
    appliedD    = appliedQ;
    pendingD    = pendingQ;
    validD      = validQ;
    doneD       = 1'b0;
    samplesDone = 1'b0;
    timedOut    = 1'b0;
`ifdef DDC_SEQ_TIMEOUT_EN
    timerD   = timerQ;
    timeoutD = timeoutQ;
    if (cfgReq) timeoutD = 1'b0;
`endif

    // The shadow always tracks the latest request; mid-sequence ones are replayed later.
    if (cfgReq) begin
      shadowD = reqCfg;
      if (stateQ != StIdle) pendingD = 1'b1;
    end

    case (stateQ)
      StIdle: begin
        if (cfgReq) begin
          stateD = StMute;
          validD = 1'b0;
        end
      end
      StMute: begin
        validD    = 1'b0;
        appliedD  = shadowQ;
        flushCntD = '0;
        stateD    = StFlush;
      end
      StFlush: begin
        if (flushCntQ == FlushLast) begin
          stateD     = StSettle;
          settleCntD = '0;
`ifdef DDC_SEQ_TIMEOUT_EN
          timerD     = '0;
`endif
        end else if (flushCntQ != FlushMax) begin
          flushCntD = flushCntQ + 1'b1;
        end
      end
      StSettle: begin
        samplesDone = syncIn && (settleCntQ == SettleLast);
        if (syncIn && settleCntQ != SettleMax) settleCntD = settleCntQ + 1'b1;
`ifdef DDC_SEQ_TIMEOUT_EN
        timedOut = !samplesDone && (timerQ == TimerLast);
        if (timerQ != TimerMax) timerD = timerQ + 1'b1;
        if (timedOut) timeoutD = 1'b1;
`endif
        if (samplesDone || timedOut) begin
          // A same-cycle request counts as pending and restarts the sequence.
          if (pendingQ || cfgReq) begin
            stateD   = StMute;
            pendingD = 1'b0;
            validD   = 1'b0;
          end else begin
            stateD = StIdle;
            doneD  = 1'b1;
            validD = samplesDone;
          end
        end
      end
      default: stateD = StFlush;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ     <= StFlush;
      flushCntQ  <= '0;
      settleCntQ <= '0;
      shadowQ    <= '0;
      appliedQ   <= '0;
      pendingQ   <= 1'b0;
      validQ     <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      flushCntQ  <= flushCntD;
      settleCntQ <= settleCntD;
      shadowQ    <= shadowD;
      appliedQ   <= appliedD;
      pendingQ   <= pendingD;
      validQ     <= validD;
      doneQ      <= doneD;
    end
  end

`ifdef DDC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timerQ   <= '0;
      timeoutQ <= 1'b0;
    end else begin
      timerQ   <= timerD;
      timeoutQ <= timeoutD;
    end
  end

  assign cfgTimeout = timeoutQ;
`else
  assign cfgTimeout = 1'b0;
`endif

  assign bypassCic            = appliedQ.bypassCic;
  assign bypassHb             = appliedQ.bypassHb;
  assign bypassFir            = appliedQ.bypassFir;
  assign enableBasebandInputs = appliedQ.enableBb;
  assign adcDecimation        = appliedQ.decimation;
  assign ddcCenterFreq        = appliedQ.centerFreq;
  assign filterReset          = (stateQ == StFlush);
  assign cfgBusy              = (stateQ != StIdle);
  assign outputValid          = validQ;
  assign syncGate             = syncIn & validQ;
  assign cfgDone              = doneQ;

endmodule
